// File: rtl/fetch_stage.sv
// RV32I IF stage with IF/ID register: owns the PC, issues one-outstanding imem fetches,
// and exposes decode fields. Define FETCH_PERF_CNT_EN to add fetched/dropped counters.
module fetch_stage #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            flush,
   input  logic            pc_sel,
   input  logic [XLEN-1:0] branch_target,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic            if_id_valid,
   output logic [XLEN-1:0] if_id_pc,
   output logic [31:0]     if_id_instr,
   output logic [6:0]      opcode,
   output logic [2:0]      funct3,
   output logic [6:0]      funct7,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_dropped
`endif
);

   typedef enum logic [1:0] {IDLE, REQ, RESP, DROP} state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic              skid_valid_q, skid_valid_d;
   logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
   logic [31:0]       skid_instr_q, skid_instr_d;
   logic              if_id_valid_q, if_id_valid_d;
   logic [XLEN-1:0]   if_id_pc_q, if_id_pc_d;
   logic [31:0]       if_id_instr_q, if_id_instr_d;

   logic              redirect;
   logic              resp_word;
   logic [XLEN-1:0]   target_pc;
   logic              unused_target_lsbs;

   assign redirect  = pc_sel | flush;
   assign resp_word = (state_q == RESP) && imem_rvalid;
   assign target_pc = {branch_target[XLEN-1:2], 2'b00};
   // Low target bits vanish in word alignment.
   assign unused_target_lsbs = ^branch_target[1:0];

   assign imem_req  = (state_q == REQ) && !(stall && skid_valid_q);
   assign imem_addr = pc_q;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_d       = state_q;
      pc_d          = pc_q;
      skid_valid_d  = skid_valid_q;
      skid_pc_d     = skid_pc_q;
      skid_instr_d  = skid_instr_q;
      if_id_valid_d = if_id_valid_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_instr_d = if_id_instr_q;

      case (state_q)
         IDLE: state_d = REQ;
         REQ:  if (imem_req && imem_gnt) state_d = redirect ? DROP : RESP;
         RESP: begin
            if (imem_rvalid) begin
               state_d = REQ;
               if (!redirect) pc_d = pc_q + XLEN'(4);
            end else if (redirect) begin
               state_d = DROP;
            end
         end
         DROP: if (imem_rvalid) state_d = REQ;
         default: state_d = IDLE;
      endcase

      // A flush alone keeps the PC, so the discarded word is fetched again.
      if (pc_sel) pc_d = target_pc;

      if (redirect) begin
         if_id_valid_d = 1'b0;
         if_id_instr_d = NOP_INSTR;
         skid_valid_d  = 1'b0;
      end else if (stall) begin
         if (resp_word) begin
            skid_valid_d = 1'b1;
            skid_pc_d    = pc_q;
            skid_instr_d = imem_rdata;
         end
      end else if (skid_valid_q) begin
         if_id_valid_d = 1'b1;
         if_id_pc_d    = skid_pc_q;
         if_id_instr_d = skid_instr_q;
         skid_valid_d  = 1'b0;
      end else if (resp_word) begin
         if_id_valid_d = 1'b1;
         if_id_pc_d    = pc_q;
         if_id_instr_d = imem_rdata;
      end else begin
         // Decode consumed the previous word; present a bubble.
         if_id_valid_d = 1'b0;
         if_id_instr_d = NOP_INSTR;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         skid_valid_q  <= 1'b0;
         skid_pc_q     <= '0;
         skid_instr_q  <= NOP_INSTR;
         if_id_valid_q <= 1'b0;
         if_id_pc_q    <= '0;
         if_id_instr_q <= NOP_INSTR;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q       <= state_d;
         pc_q          <= pc_d;
         skid_valid_q  <= skid_valid_d;
         skid_pc_q     <= skid_pc_d;
         skid_instr_q  <= skid_instr_d;
         if_id_valid_q <= if_id_valid_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_instr_q <= if_id_instr_d;
      end
   end

   assign if_id_valid = if_id_valid_q;
   assign if_id_pc    = if_id_pc_q;
   assign if_id_instr = if_id_instr_q;
   assign opcode      = if_id_instr_q[6:0];
   assign funct3      = if_id_instr_q[14:12];
   assign funct7      = if_id_instr_q[31:25];
   assign rs1         = if_id_instr_q[19:15];
   assign rs2         = if_id_instr_q[24:20];
   assign rd          = if_id_instr_q[11:7];

`ifdef FETCH_PERF_CNT_EN
   logic        fetch_inc, drop_inc;
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_dropped_q, perf_dropped_d;

   always_comb begin
      fetch_inc      = !redirect && !stall && (skid_valid_q || resp_word);
      drop_inc       = imem_rvalid && ((state_q == DROP) || ((state_q == RESP) && redirect));
      perf_fetched_d = perf_fetched_q + {31'd0, fetch_inc};
      perf_dropped_d = perf_dropped_q + {31'd0, drop_inc};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched_q <= '0;
         perf_dropped_q <= '0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_dropped_q <= perf_dropped_d;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_dropped = perf_dropped_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: memory model with configurable latency,
// IF/ID scoreboard, decode-field vector table and hand sequences for corner cases.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n, stall, flush, pc_sel;
   logic [31:0] branch_target;
   logic        imem_req, imem_gnt, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic        if_id_valid;
   logic [31:0] if_id_pc, if_id_instr;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rs1, rs2, rd;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_dropped;
`endif

   fetch_stage dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .pc_sel(pc_sel),
      .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
      .opcode(opcode), .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd)
`ifdef FETCH_PERF_CNT_EN
      , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [4:0]  rs1, rs2, rd;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } sb_t;

   vec_t        tbl [6];
   logic [31:0] mem_arr [64];
   sb_t         sb_q [$];

   int          checks = 0, errors = 0;
   int          lat = 1, pend_cnt = 0, cyc = 0, last_pop_cyc = -1;
   bit          gnt_en = 1, stale_rv = 0, doomed = 0, popped = 0, cadence_en = 0;
   logic [31:0] pend_addr = '0, exp_pc = '0;
   bit          e_valid = 0;
   logic [31:0] e_pc = '0, e_instr = NOP;
   int          exp_fetched = 0, exp_dropped = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic reset_model();
      pend_cnt = 0; doomed = 0; exp_pc = '0; sb_q.delete();
      e_valid = 0; e_pc = '0; e_instr = NOP;
      exp_fetched = 0; exp_dropped = 0; last_pop_cyc = -1;
   endtask

   // Hold reset for two edges and release just after a rising edge.
   task automatic apply_reset();
      rst_n = 1'b0;
      imem_rvalid = 1'b0;
      reset_model();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // One clock: drive memory at negedge, check address, then check IF/ID after the edge.
   task automatic step();
      bit          deliver, redirect, stall_s, granted;
      logic [31:0] g_addr;
      sb_t         s;
      @(negedge clk);
      deliver     = (pend_cnt == 1);
      imem_rvalid = deliver || stale_rv;
      imem_rdata  = deliver ? mem_arr[pend_addr[7:2]] : 32'hDEAD_BEEF;
      imem_gnt    = gnt_en;
      #1;
      redirect = pc_sel || flush;
      stall_s  = stall;
      granted  = imem_req && imem_gnt;
      g_addr   = imem_addr;
      if (imem_req) check("imem_addr", imem_addr, exp_pc);
      if (deliver) begin
         if (redirect || doomed) exp_dropped++;
         else begin
            sb_q.push_back('{pend_addr, mem_arr[pend_addr[7:2]]});
            exp_pc = exp_pc + 32'd4;
         end
         doomed = 0;
      end
      if (redirect) begin
         sb_q.delete();
         if (pend_cnt > 1) doomed = 1;
         if (pc_sel) exp_pc = {branch_target[31:2], 2'b00};
      end
      @(posedge clk);
      cyc++;
      if (pend_cnt > 0) pend_cnt--;
      if (granted) begin
         pend_cnt  = lat;
         pend_addr = g_addr;
         doomed    = redirect;
      end
      #1;
      if (redirect) begin
         e_valid = 0; e_instr = NOP;
      end else if (!stall_s) begin
         if (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            e_valid = 1; e_pc = s.pc; e_instr = s.instr;
            exp_fetched++;
            popped = 1;
            if (cadence_en && last_pop_cyc >= 0) check("cadence", cyc - last_pop_cyc, 2);
            last_pop_cyc = cyc;
         end else begin
            e_valid = 0; e_instr = NOP;
         end
      end
      check("if_id_valid", if_id_valid, e_valid);
      if (e_valid) check("if_id_pc", if_id_pc, e_pc);
      check("if_id_instr", if_id_instr, e_instr);
      check("fields", {funct7, rs2, rs1, funct3, rd, opcode}, e_instr);
`ifdef FETCH_PERF_CNT_EN
      check("perf_fetched", perf_fetched, exp_fetched);
      check("perf_dropped", perf_dropped, exp_dropped);
`endif
   endtask

   task automatic wait_pop();
      int n = 0;
      popped = 0;
      while (!popped && n < 12) begin
         step();
         n++;
      end
      check("pop_timeout", {31'd0, popped}, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{32'h0050_0093, 7'h13, 3'h0, 7'h00, 5'd0,  5'd5,  5'd1};
      tbl[1] = '{32'h4020_8133, 7'h33, 3'h0, 7'h20, 5'd1,  5'd2,  5'd2};
      tbl[2] = '{32'h0062_A023, 7'h23, 3'h2, 7'h00, 5'd5,  5'd6,  5'd0};
      tbl[3] = '{32'hFFFF_FFFF, 7'h7F, 3'h7, 7'h7F, 5'd31, 5'd31, 5'd31};
      tbl[4] = '{32'h0000_0000, 7'h00, 3'h0, 7'h00, 5'd0,  5'd0,  5'd0};
      tbl[5] = '{32'h8000_00B7, 7'h37, 3'h0, 7'h40, 5'd0,  5'd0,  5'd1};
      for (int i = 0; i < 64; i++) mem_arr[i] = NOP | (32'(i) << 20);
      for (int i = 0; i < 6; i++) mem_arr[i] = tbl[i].instr;

      stall = 0; flush = 0; pc_sel = 0; branch_target = '0;
      imem_gnt = 1; imem_rvalid = 0; imem_rdata = '0;
      apply_reset();

      // First fetch after reset release.
      cadence_en = 1;
      check("idle_no_req", imem_req, 0);
      step();
      check("first_req", imem_req, 1);
      check("first_addr", imem_addr, 32'h0);
      step();
      check("resp_no_req", imem_req, 0);
      step();
      check("t1_valid", if_id_valid, 1);
      check("t1_pc", if_id_pc, 32'h0);
      check("t1_opcode", opcode, 7'h13);
      check("t1_rd", rd, 5'd1);
      check("t1_funct3", funct3, 3'd0);
      check("t1_next_addr", imem_addr, 32'h4);

      // Sequential fetch against the decode vector table.
      for (int i = 1; i < 6; i++) begin
         wait_pop();
         check($sformatf("v%0d_pc", i), if_id_pc, 32'(i * 4));
         check($sformatf("v%0d_opcode", i), opcode, tbl[i].opcode);
         check($sformatf("v%0d_funct3", i), funct3, tbl[i].funct3);
         check($sformatf("v%0d_funct7", i), funct7, tbl[i].funct7);
         check($sformatf("v%0d_rs1", i), rs1, tbl[i].rs1);
         check($sformatf("v%0d_rs2", i), rs2, tbl[i].rs2);
         check($sformatf("v%0d_rd", i), rd, tbl[i].rd);
      end
      cadence_en = 0;

      // Redirect during RESP with the response arriving the same cycle.
      step();
      check("redir_in_resp", imem_req, 0);
      pc_sel = 1; branch_target = 32'h103;
      step();
      pc_sel = 0;
      check("redir_req", imem_req, 1);
      check("redir_addr", imem_addr, 32'h100);
      check("redir_valid", if_id_valid, 0);
`ifdef FETCH_PERF_CNT_EN
      check("redir_dropped", perf_dropped, 1);
`endif

      // Redirect before the response (RESP -> DROP), then again while in DROP.
      lat = 3;
      step();
      pc_sel = 1; branch_target = 32'h20;
      step();
      check("drop_no_req", imem_req, 0);
      branch_target = 32'h26;
      step();
      pc_sel = 0;
      check("drop_hold_no_req", imem_req, 0);
      step();
      check("drop_exit_req", imem_req, 1);
      check("drop_exit_addr", imem_addr, 32'h24);
      lat = 1;
      wait_pop();
      check("after_drop_pc", if_id_pc, 32'h24);

      // Grant withheld: request and address must hold.
      gnt_en = 0;
      repeat (3) begin
         step();
         check("nognt_req", imem_req, 1);
         check("nognt_addr", imem_addr, 32'h28);
      end
      gnt_en = 1;
      wait_pop();
      check("after_nognt_pc", if_id_pc, 32'h28);

      // Stall for five cycles while a response lands in the skid buffer.
      stall = 1;
      step();
      check("stall_hold_pc", if_id_pc, 32'h28);
      step();
      check("skid_full_no_req", imem_req, 0);
      repeat (3) begin
         step();
         check("stall_no_req", imem_req, 0);
         check("stall_hold_valid", if_id_valid, 1);
      end
      stall = 0;
      #1 check("drain_req", imem_req, 1);
      step();
      check("drain_valid", if_id_valid, 1);
      check("drain_pc", if_id_pc, 32'h2C);

      // Flush without pc_sel on the cycle the response arrives.
      flush = 1;
      step();
      flush = 0;
      check("flush_instr", if_id_instr, NOP);
      check("flush_valid", if_id_valid, 0);
      check("flush_addr", imem_addr, 32'h30);
`ifdef FETCH_PERF_CNT_EN
      check("flush_dropped", perf_dropped, 3);
`endif

      // Asynchronous reset mid-RESP, then a stale response after release.
      wait_pop();
      check("pre_reset_pc", if_id_pc, 32'h30);
      stall = 1; lat = 3;
      step();
      check("pre_reset_resp", imem_req, 0);
      rst_n = 0; stall = 0;
      #1;
      check("rst_req", imem_req, 0);
      check("rst_valid", if_id_valid, 0);
      check("rst_pc", if_id_pc, 32'h0);
      check("rst_instr", if_id_instr, NOP);
      check("rst_opcode", opcode, 7'h13);
`ifdef FETCH_PERF_CNT_EN
      check("rst_fetched", perf_fetched, 0);
      check("rst_dropped", perf_dropped, 0);
`endif
      apply_reset();
      lat = 1;
      stale_rv = 1;
      check("rst2_idle", imem_req, 0);
      step();
      check("rst2_req", imem_req, 1);
      check("rst2_addr", imem_addr, 32'h0);
      step();
      stale_rv = 0;
      check("rst2_resp", imem_req, 0);
      step();
      check("rst2_valid", if_id_valid, 1);
      check("rst2_pc", if_id_pc, 32'h0);
      check("rst2_instr", if_id_instr, 32'h0050_0093);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
